// File: rtl/bus_master_if.sv
// ---------------------------------------------------------------------------
// bus_master_if
//
// Per-master initiator front end for the shared 4-master/8-slave bus.
// Converts a simple level-sensitive core request into the bus master
// handshake (request -> grant -> one-cycle address strobe -> wait for
// slave ready) and returns read data / write completion to the core with
// a one-cycle acknowledge. A watchdog aborts accesses whose slave never
// asserts ready.
//
// States:
//   IDLE   | waiting for core_req; core inputs are latched here only
//   REQ    | m_req_ low, waiting (unbounded) for m_grnt_ low
//   ACCESS | m_as_ low for exactly this cycle, watchdog starts at 1
//   WAIT   | m_as_ high, waiting for m_rdy or watchdog == TIMEOUT
//   DONE   | core_ack high, m_req_ released for re-arbitration
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   core_req/addr/rw/
//   core_wr_data          - core-side request (sampled only in IDLE)
//   core_ack/err/rd_data  - one-cycle completion pulse, abort flag, read data
//   core_busy             - high whenever the FSM is not in IDLE
//   m_req_/m_grnt_        - bus request / grant, active-low
//   m_addr/m_rw/m_wr_data - bus address phase, stable for the whole transfer
//   m_as_                 - address strobe, active-low
//   m_busy                - transfer-type busy flag, always 0 here
//   m_rd_data/m_rdy       - muxed slave read data and ready
//
// Every output comes straight from a flop. Output flops are loaded from
// the next-state value so they change in the same cycle as the state.
// ---------------------------------------------------------------------------
module bus_master_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  // core side
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_rw,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic              core_ack,
  output logic              core_err,
  output logic [DATA_W-1:0] core_rd_data,
  output logic              core_busy,
  // bus side
  output logic              m_req_,
  input  logic              m_grnt_,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_as_,
  output logic              m_rw,
  output logic              m_busy,
  output logic [DATA_W-1:0] m_wr_data,
  input  logic [DATA_W-1:0] m_rd_data,
  input  logic              m_rdy
);

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_ACCESS = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         wd_q, wd_d;
  logic                m_req_q, m_req_d;
  logic                m_as_q, m_as_d;
  logic                m_rw_q, m_rw_d;
  logic                m_busy_q, m_busy_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wr_data_q, m_wr_data_d;
  logic                core_ack_q, core_ack_d;
  logic                core_err_q, core_err_d;
  logic                core_busy_q, core_busy_d;
  logic [DATA_W-1:0]   core_rd_data_q, core_rd_data_d;

  // -------------------------------------------------------------------------
  // Next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    wd_d           = wd_q;
    m_addr_d       = m_addr_q;
    m_rw_d         = m_rw_q;
    m_wr_data_d    = m_wr_data_q;
    core_rd_data_d = core_rd_data_q;
    core_err_d     = 1'b0;
    m_busy_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (core_req) begin
          m_addr_d    = core_addr;
          m_rw_d      = core_rw;
          m_wr_data_d = core_wr_data;
          state_d     = S_REQ;
        end
      end

      S_REQ: begin
        if (!m_grnt_) begin
          state_d = S_ACCESS;
          // Watchdog counts ACCESS as the first cycle of the access.
          wd_d    = 16'd1;
        end
      end

      S_ACCESS: begin
        if (m_rdy) begin
          state_d = S_DONE;
          if (m_rw_q) begin
            core_rd_data_d = m_rd_data;
          end
        end else begin
          state_d = S_WAIT;
          wd_d    = 16'(wd_q + 16'd1);
        end
      end

      S_WAIT: begin
        // Ready has priority over the timeout in the same cycle.
        if (m_rdy) begin
          state_d = S_DONE;
          if (m_rw_q) begin
            core_rd_data_d = m_rd_data;
          end
        end else if (wd_q == TIMEOUT_W) begin
          state_d        = S_DONE;
          core_err_d     = 1'b1;
          core_rd_data_d = '0;
        end else begin
          wd_d = 16'(wd_q + 16'd1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output flops follow the state being entered.
    m_req_d     = !((state_d == S_REQ) || (state_d == S_ACCESS) || (state_d == S_WAIT));
    m_as_d      = (state_d != S_ACCESS);
    core_ack_d  = (state_d == S_DONE);
    core_busy_d = (state_d != S_IDLE);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      wd_q           <= '0;
      m_req_q        <= 1'b1;
      m_as_q         <= 1'b1;
      m_rw_q         <= 1'b1;
      m_busy_q       <= 1'b0;
      m_addr_q       <= '0;
      m_wr_data_q    <= '0;
      core_ack_q     <= 1'b0;
      core_err_q     <= 1'b0;
      core_busy_q    <= 1'b0;
      core_rd_data_q <= '0;
    end else begin
      state_q        <= state_d;
      wd_q           <= wd_d;
      m_req_q        <= m_req_d;
      m_as_q         <= m_as_d;
      m_rw_q         <= m_rw_d;
      m_busy_q       <= m_busy_d;
      m_addr_q       <= m_addr_d;
      m_wr_data_q    <= m_wr_data_d;
      core_ack_q     <= core_ack_d;
      core_err_q     <= core_err_d;
      core_busy_q    <= core_busy_d;
      core_rd_data_q <= core_rd_data_d;
    end
  end

  assign m_req_       = m_req_q;
  assign m_as_        = m_as_q;
  assign m_rw         = m_rw_q;
  assign m_busy       = m_busy_q;
  assign m_addr       = m_addr_q;
  assign m_wr_data    = m_wr_data_q;
  assign core_ack     = core_ack_q;
  assign core_err     = core_err_q;
  assign core_busy    = core_busy_q;
  assign core_rd_data = core_rd_data_q;

endmodule

// File: tb/tb_bus_master_if.sv
// ---------------------------------------------------------------------------
// tb_bus_master_if
//
// Directed bench for bus_master_if (ADDR_W=32, DATA_W=32, TIMEOUT=16).
// Inputs change 1 ns after a rising edge; outputs are checked at the same
// point, so each tick() moves to the next cycle with the registered
// outputs for that cycle visible. Cycle 0 of each scenario is the IDLE
// cycle in which core_req is presented.
// ---------------------------------------------------------------------------
module tb_bus_master_if;

  logic        clk;
  logic        reset;
  logic        core_req;
  logic [31:0] core_addr;
  logic        core_rw;
  logic [31:0] core_wr_data;
  logic        core_ack;
  logic        core_err;
  logic [31:0] core_rd_data;
  logic        core_busy;
  logic        m_req_;
  logic        m_grnt_;
  logic [31:0] m_addr;
  logic        m_as_;
  logic        m_rw;
  logic        m_busy;
  logic [31:0] m_wr_data;
  logic [31:0] m_rd_data;
  logic        m_rdy;

  int errors = 0;
  int checks = 0;

  bus_master_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .core_req     (core_req),
    .core_addr    (core_addr),
    .core_rw      (core_rw),
    .core_wr_data (core_wr_data),
    .core_ack     (core_ack),
    .core_err     (core_err),
    .core_rd_data (core_rd_data),
    .core_busy    (core_busy),
    .m_req_       (m_req_),
    .m_grnt_      (m_grnt_),
    .m_addr       (m_addr),
    .m_as_        (m_as_),
    .m_rw         (m_rw),
    .m_busy       (m_busy),
    .m_wr_data    (m_wr_data),
    .m_rd_data    (m_rd_data),
    .m_rdy        (m_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    core_req = 1'b0; core_addr = '0; core_rw = 1'b0; core_wr_data = '0;
    m_grnt_ = 1'b1; m_rd_data = '0; m_rdy = 1'b0;
    tick();
    tick();
    checks++;
    if ({m_req_, m_as_, m_rw, m_busy} !== 4'b1110) begin
      errors++;
      $display("FAIL reset_bus_ctl: got req_/as_/rw/busy=%b required 1110", {m_req_, m_as_, m_rw, m_busy});
    end
    checks++;
    if (m_addr !== 32'h0 || m_wr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus_data: got addr=%h wdata=%h required 0/0", m_addr, m_wr_data);
    end
    checks++;
    if ({core_ack, core_err, core_busy} !== 3'b000 || core_rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_core: got ack/err/busy=%b rd=%h required 000/0", {core_ack, core_err, core_busy}, core_rd_data);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (core_busy !== 1'b0 || m_req_ !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b req_=%b required 0/1", core_busy, m_req_);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_immediate_read();
    // c0 IDLE
    core_req = 1'b1; core_addr = 32'h1000_0004; core_rw = 1'b1; core_wr_data = 32'h0;
    m_grnt_ = 1'b0; m_rdy = 1'b1; m_rd_data = 32'hDEAD_BEEF;
    tick();  // c1 REQ
    core_req = 1'b0; core_addr = 32'h0BAD_0BAD;
    checks++;
    if (m_req_ !== 1'b0 || m_as_ !== 1'b1 || core_busy !== 1'b1 || core_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd_req_cycle: got req_=%b as_=%b busy=%b ack=%b required 0/1/1/0", m_req_, m_as_, core_busy, core_ack);
    end
    tick();  // c2 ACCESS
    checks++;
    if (m_as_ !== 1'b0 || m_addr !== 32'h1000_0004 || m_rw !== 1'b1 || core_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd_access: got as_=%b addr=%h rw=%b ack=%b required 0/10000004/1/0", m_as_, m_addr, m_rw, core_ack);
    end
    tick();  // c3 DONE
    m_rdy = 1'b0; m_rd_data = 32'h0;
    checks++;
    if (core_ack !== 1'b1 || core_err !== 1'b0 || core_rd_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_done: got ack=%b err=%b rd=%h required 1/0/deadbeef", core_ack, core_err, core_rd_data);
    end
    checks++;
    if (m_req_ !== 1'b1 || m_as_ !== 1'b1 || core_busy !== 1'b1) begin
      errors++;
      $display("FAIL rd_done_bus: got req_=%b as_=%b busy=%b required 1/1/1", m_req_, m_as_, core_busy);
    end
    tick();  // c4 IDLE
    checks++;
    if (core_ack !== 1'b0 || core_busy !== 1'b0 || core_rd_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_idle: got ack=%b busy=%b rd=%h required 0/0/deadbeef", core_ack, core_busy, core_rd_data);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_delayed_write();
    core_req = 1'b1; core_addr = 32'h2000_0000; core_rw = 1'b0; core_wr_data = 32'h1234_5678;
    m_grnt_ = 1'b1; m_rdy = 1'b0; m_rd_data = 32'h7777_7777;
    tick();  // c1 REQ
    core_req = 1'b0; core_addr = 32'hFFFF_FFFF; core_rw = 1'b1; core_wr_data = 32'h0;
    for (int c = 2; c <= 5; c++) begin
      tick();  // c2..c5 still REQ, no grant
      checks++;
      if (m_req_ !== 1'b0 || m_as_ !== 1'b1 || core_ack !== 1'b0) begin
        errors++;
        $display("FAIL wr_grant_wait c%0d: got req_=%b as_=%b ack=%b required 0/1/0", c, m_req_, m_as_, core_ack);
      end
    end
    m_grnt_ = 1'b0;
    tick();  // c6 ACCESS
    m_grnt_ = 1'b1;  // ignored from here on
    checks++;
    if (m_as_ !== 1'b0) begin
      errors++;
      $display("FAIL wr_access_as: got as_=%b required 0", m_as_);
    end
    for (int c = 6; c <= 10; c++) begin
      if (c > 6) tick();  // c7..c10 WAIT
      checks++;
      if (m_addr !== 32'h2000_0000 || m_wr_data !== 32'h1234_5678 || m_rw !== 1'b0 || m_req_ !== 1'b0) begin
        errors++;
        $display("FAIL wr_stable c%0d: got addr=%h wdata=%h rw=%b req_=%b required 20000000/12345678/0/0", c, m_addr, m_wr_data, m_rw, m_req_);
      end
      if (c > 6) begin
        checks++;
        if (m_as_ !== 1'b1 || core_ack !== 1'b0) begin
          errors++;
          $display("FAIL wr_wait c%0d: got as_=%b ack=%b required 1/0", c, m_as_, core_ack);
        end
      end
    end
    m_rdy = 1'b1;  // ready during the fourth WAIT cycle
    tick();  // c11 DONE
    m_rdy = 1'b0;
    checks++;
    if (core_ack !== 1'b1 || core_err !== 1'b0 || core_rd_data !== 32'hDEAD_BEEF || m_req_ !== 1'b1) begin
      errors++;
      $display("FAIL wr_done: got ack=%b err=%b rd=%h req_=%b required 1/0/deadbeef/1", core_ack, core_err, core_rd_data, m_req_);
    end
    tick();  // c12 IDLE
    checks++;
    if (core_ack !== 1'b0 || core_busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_idle: got ack=%b busy=%b required 0/0", core_ack, core_busy);
    end
  endtask

  // -------------------------------------------------------------------------
  // ACCESS at c2, watchdog hits TIMEOUT in c17, completion in c18.
  task automatic test_timeout(input bit late_rdy);
    core_req = 1'b1; core_addr = 32'h5000_0000; core_rw = 1'b1; core_wr_data = 32'h0;
    m_grnt_ = 1'b0; m_rdy = 1'b0; m_rd_data = 32'hA5A5_A5A5;
    tick();  // c1 REQ
    core_req = 1'b0;
    tick();  // c2 ACCESS
    checks++;
    if (m_as_ !== 1'b0) begin
      errors++;
      $display("FAIL to_access late=%0d: got as_=%b required 0", late_rdy, m_as_);
    end
    for (int c = 3; c <= 17; c++) begin
      tick();
      checks++;
      if (core_ack !== 1'b0 || core_busy !== 1'b1 || m_as_ !== 1'b1) begin
        errors++;
        $display("FAIL to_wait late=%0d c%0d: got ack=%b busy=%b as_=%b required 0/1/1", late_rdy, c, core_ack, core_busy, m_as_);
      end
    end
    if (late_rdy) m_rdy = 1'b1;
    tick();  // c18 DONE
    m_rdy = 1'b0;
    checks++;
    if (late_rdy) begin
      if (core_ack !== 1'b1 || core_err !== 1'b0 || core_rd_data !== 32'hA5A5_A5A5) begin
        errors++;
        $display("FAIL rdy_on_timeout: got ack=%b err=%b rd=%h required 1/0/a5a5a5a5", core_ack, core_err, core_rd_data);
      end
    end else begin
      if (core_ack !== 1'b1 || core_err !== 1'b1 || core_rd_data !== 32'h0) begin
        errors++;
        $display("FAIL timeout_done: got ack=%b err=%b rd=%h required 1/1/0", core_ack, core_err, core_rd_data);
      end
    end
    tick();  // c19 IDLE
    checks++;
    if (core_ack !== 1'b0 || core_err !== 1'b0 || core_busy !== 1'b0 || m_req_ !== 1'b1) begin
      errors++;
      $display("FAIL to_idle late=%0d: got ack=%b err=%b busy=%b req_=%b required 0/0/0/1", late_rdy, core_ack, core_err, core_busy, m_req_);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    core_req = 1'b1; core_addr = 32'h3000_0000; core_rw = 1'b1; core_wr_data = 32'h0;
    m_grnt_ = 1'b0; m_rdy = 1'b1; m_rd_data = 32'h1111_1111;
    tick();  // c1 REQ
    tick();  // c2 ACCESS
    tick();  // c3 DONE, core_req still high
    m_rd_data = 32'h0BAD_F00D;
    core_addr = 32'h4000_0008;
    checks++;
    if (core_ack !== 1'b1 || core_rd_data !== 32'h1111_1111 || m_req_ !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got ack=%b rd=%h req_=%b required 1/11111111/1", core_ack, core_rd_data, m_req_);
    end
    tick();  // c4 IDLE, samples the new address
    checks++;
    if (m_req_ !== 1'b1 || core_ack !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got req_=%b ack=%b required 1/0", m_req_, core_ack);
    end
    tick();  // c5 REQ
    core_req = 1'b0; core_addr = 32'hDEAD_0000;
    checks++;
    if (m_req_ !== 1'b0 || m_addr !== 32'h4000_0008) begin
      errors++;
      $display("FAIL b2b_second_req: got req_=%b addr=%h required 0/40000008", m_req_, m_addr);
    end
    tick();  // c6 ACCESS
    tick();  // c7 DONE
    m_rdy = 1'b0;
    checks++;
    if (core_ack !== 1'b1 || core_rd_data !== 32'h0BAD_F00D || core_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got ack=%b rd=%h err=%b required 1/0badf00d/0", core_ack, core_rd_data, core_err);
    end
    tick();  // c8 IDLE, core_req low so no third transfer
    tick();
    checks++;
    if (core_busy !== 1'b0 || m_req_ !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stop: got busy=%b req_=%b required 0/1", core_busy, m_req_);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid_wait();
    core_req = 1'b1; core_addr = 32'h6000_0010; core_rw = 1'b0; core_wr_data = 32'hFFFF_0000;
    m_grnt_ = 1'b0; m_rdy = 1'b0; m_rd_data = 32'h0;
    tick();  // c1 REQ
    core_req = 1'b0;
    tick();  // c2 ACCESS
    tick();  // c3 WAIT
    tick();  // c4 WAIT
    checks++;
    if (m_wr_data !== 32'hFFFF_0000 || m_rw !== 1'b0 || core_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got wdata=%h rw=%b busy=%b required ffff0000/0/1", m_wr_data, m_rw, core_busy);
    end
    #2;
    reset = 1'b1;  // between clock edges
    #1;
    checks++;
    if ({m_req_, m_as_, m_rw, m_busy} !== 4'b1110 || m_addr !== 32'h0 || m_wr_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_async_bus: got req_/as_/rw/busy=%b addr=%h wdata=%h required 1110/0/0", {m_req_, m_as_, m_rw, m_busy}, m_addr, m_wr_data);
    end
    checks++;
    if ({core_ack, core_err, core_busy} !== 3'b000 || core_rd_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_async_core: got ack/err/busy=%b rd=%h required 000/0", {core_ack, core_err, core_busy}, core_rd_data);
    end
    m_rdy = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (core_ack !== 1'b0 || core_busy !== 1'b0 || m_req_ !== 1'b1) begin
        errors++;
        $display("FAIL rst_after c%0d: got ack=%b busy=%b req_=%b required 0/0/1", c, core_ack, core_busy, m_req_);
      end
    end
    m_rdy = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_immediate_read();
    test_delayed_write();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_back_to_back();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
